// File: rtl/status_reg_cond_unit_pkg.sv
// Shared definitions for the flag/condition path: flag bit positions,
// ARM condition codes, and the ALU command set used by the ALU and controller.
package status_reg_cond_unit_pkg;

    localparam int FLAG_W = 4;
    localparam int COND_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_MI = 4'h4;
    localparam logic [COND_W-1:0] COND_PL = 4'h5;
    localparam logic [COND_W-1:0] COND_VS = 4'h6;
    localparam logic [COND_W-1:0] COND_VC = 4'h7;
    localparam logic [COND_W-1:0] COND_HI = 4'h8;
    localparam logic [COND_W-1:0] COND_LS = 4'h9;
    localparam logic [COND_W-1:0] COND_GE = 4'hA;
    localparam logic [COND_W-1:0] COND_LT = 4'hB;
    localparam logic [COND_W-1:0] COND_GT = 4'hC;
    localparam logic [COND_W-1:0] COND_LE = 4'hD;
    localparam logic [COND_W-1:0] COND_AL = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_EOR = 4'h1,
        ALU_SUB = 4'h2,
        ALU_RSB = 4'h3,
        ALU_ADD = 4'h4,
        ALU_ADC = 4'h5,
        ALU_SBC = 4'h6,
        ALU_RSC = 4'h7,
        ALU_TST = 4'h8,
        ALU_TEQ = 4'h9,
        ALU_CMP = 4'hA,
        ALU_CMN = 4'hB,
        ALU_ORR = 4'hC,
        ALU_MOV = 4'hD,
        ALU_BIC = 4'hE,
        ALU_MVN = 4'hF
    } alu_cmd_e;

endpackage

// File: rtl/status_reg_cond_unit_cond_check.sv
// Pure combinational ARM condition evaluator; shared with the branch unit.
module cond_check
    import status_reg_cond_unit_pkg::*;
(
    input  logic [COND_W-1:0] cond_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic              pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_reg_cond_unit.sv
// Architectural {N,Z,C,V} status register with a one-deep exception shadow,
// same-cycle ALU flag bypass and condition evaluation for the ID instruction.
module status_reg_cond_unit
    import status_reg_cond_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    input  logic              exe_valid_i,
    input  logic              exe_s_i,
    input  logic [FLAG_W-1:0] alu_status_i,
    input  logic [COND_W-1:0] id_cond_i,
    input  logic              exc_entry_i,
    input  logic              exc_return_i,
    output logic [FLAG_W-1:0] status_out_o,
    output logic [FLAG_W-1:0] shadow_out_o,
    output logic              cond_pass_o
);

    logic [FLAG_W-1:0] status_q, status_d;
    logic [FLAG_W-1:0] shadow_q, shadow_d;
    logic [FLAG_W-1:0] eff;
    logic              producing;
    logic              wr;

    // A frozen producer still holds the newest flags, so the bypass ignores freeze.
    assign producing = exe_valid_i & exe_s_i & ~flush_i;
    assign wr        = producing & ~freeze_i;
    assign eff       = producing ? alu_status_i : status_q;

    always_comb begin
        status_d = status_q;
        if (exc_return_i) begin
            status_d = shadow_q;
        end else if (wr) begin
            status_d = alu_status_i;
        end
        shadow_d = exc_entry_i ? eff : shadow_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
            shadow_q <= '0;
        end else begin
            status_q <= status_d;
            shadow_q <= shadow_d;
        end
    end

    cond_check u_cond_check (
        .cond_i  (id_cond_i),
        .flags_i (eff),
        .pass_o  (cond_pass_o)
    );

    assign status_out_o = status_q;
    assign shadow_out_o = shadow_q;

endmodule

// File: tb/tb_status_reg_cond_unit.sv
// Directed bench for status_reg_cond_unit: condition vector table, full
// condition/flag sweep against an independent model, and multi-cycle sequences.
module tb_status_reg_cond_unit;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       freeze;
    logic       exeValid;
    logic       exeS;
    logic [3:0] aluStatus;
    logic [3:0] idCond;
    logic       excEntry;
    logic       excReturn;
    logic [3:0] statusOut;
    logic [3:0] shadowOut;
    logic       condPass;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       expPass;
    } condVec_t;

    condVec_t vecs[20];

    status_reg_cond_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .freeze_i     (freeze),
        .exe_valid_i  (exeValid),
        .exe_s_i      (exeS),
        .alu_status_i (aluStatus),
        .id_cond_i    (idCond),
        .exc_entry_i  (excEntry),
        .exc_return_i (excReturn),
        .status_out_o (statusOut),
        .shadow_out_o (shadowOut),
        .cond_pass_o  (condPass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on the ARM pairing: odd codes invert the even base test.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n ~^ v);
            3'd6: base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic fl, input logic fr,
                                 input logic [3:0] alu, input logic [3:0] cond,
                                 input logic ent, input logic ret);
        exeValid  = v;
        exeS      = s;
        flush     = fl;
        freeze    = fr;
        aluStatus = alu;
        idCond    = cond;
        excEntry  = ent;
        excReturn = ret;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hE, 1'b0, 1'b0);
    endtask

    // Load the status register through a normal S write.
    task automatic loadStatus(input logic [3:0] val);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, val, 4'hE, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        vecs[0]  = '{4'h0, 4'b0100, 1'b1};
        vecs[1]  = '{4'h1, 4'b0100, 1'b0};
        vecs[2]  = '{4'h2, 4'b0010, 1'b1};
        vecs[3]  = '{4'h3, 4'b0010, 1'b0};
        vecs[4]  = '{4'h4, 4'b1000, 1'b1};
        vecs[5]  = '{4'h5, 4'b1000, 1'b0};
        vecs[6]  = '{4'h6, 4'b0001, 1'b1};
        vecs[7]  = '{4'h7, 4'b0001, 1'b0};
        vecs[8]  = '{4'h8, 4'b0010, 1'b1};
        vecs[9]  = '{4'h8, 4'b0110, 1'b0};
        vecs[10] = '{4'h9, 4'b0110, 1'b1};
        vecs[11] = '{4'h9, 4'b0010, 1'b0};
        vecs[12] = '{4'hA, 4'b1000, 1'b0};
        vecs[13] = '{4'hA, 4'b1001, 1'b1};
        vecs[14] = '{4'hB, 4'b1000, 1'b1};
        vecs[15] = '{4'hC, 4'b0000, 1'b1};
        vecs[16] = '{4'hC, 4'b0100, 1'b0};
        vecs[17] = '{4'hD, 4'b0001, 1'b1};
        vecs[18] = '{4'hE, 4'b0000, 1'b1};
        vecs[19] = '{4'hF, 4'b1111, 1'b0};

        // Reset for two cycles, then reset values and the AL/NV constants.
        rst = 1'b1;
        idle();
        tick();
        tick();
        checkOutput("reset status", statusOut, 4'b0000);
        checkOutput("reset shadow", shadowOut, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hE, 1'b0, 1'b0);
        checkOutput("reset AL", {3'b0, condPass}, 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hF, 1'b0, 1'b0);
        checkOutput("reset NV", {3'b0, condPass}, 4'd0);
        rst = 1'b0;
        idle();
        tick();

        // Same-cycle bypass of an S write, visible on status one edge later.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 4'h0, 1'b0, 1'b0);
        checkOutput("bypass EQ pass", {3'b0, condPass}, 4'd1);
        checkOutput("bypass status old", statusOut, 4'b0000);
        tick();
        idle();
        checkOutput("write status", statusOut, 4'b0100);

        // Flushed producer: neither bypassed nor written.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 4'h0, 1'b0, 1'b0);
        checkOutput("flush EQ", {3'b0, condPass}, 4'd0);
        tick();
        idle();
        checkOutput("flush status", statusOut, 4'b0000);

        // Frozen producer: bypass active, write held off until release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 4'h2, 1'b0, 1'b0);
            checkOutput("freeze CS", {3'b0, condPass}, 4'd1);
            checkOutput("freeze status", statusOut, 4'b0000);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'h2, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("unfreeze status", statusOut, 4'b0010);

        // Exception save, overwrite, restore.
        loadStatus(4'b1001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hE, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("entry shadow", shadowOut, 4'b1001);
        loadStatus(4'b0100);
        checkOutput("post-entry write", statusOut, 4'b0100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hE, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("return status", statusOut, 4'b1001);

        // Entry and return together swap the two registers.
        loadStatus(4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'hE, 1'b1, 1'b1);
        tick();
        idle();
        checkOutput("swap status", statusOut, 4'b1001);
        checkOutput("swap shadow", shadowOut, 4'b0110);

        // Return beats a concurrent ALU write; entry captures the in-flight write.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 4'hE, 1'b1, 1'b1);
        tick();
        idle();
        checkOutput("return over wr", statusOut, 4'b0110);
        checkOutput("entry in-flight", shadowOut, 4'b1111);

        // Reset wins over freeze and a pending write.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 4'hE, 1'b0, 1'b0);
        tick();
        checkOutput("reset over freeze st", statusOut, 4'b0000);
        checkOutput("reset over freeze sh", shadowOut, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 4'h0, 1'b0, 1'b0);
        checkOutput("reset bypass EQ", {3'b0, condPass}, 4'd1);
        rst = 1'b0;
        idle();
        tick();

        // Hand-computed vector table, driven through the frozen bypass path.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, vecs[i].flags, vecs[i].cond, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d cond=%h flags=%b", i, vecs[i].cond, vecs[i].flags),
                        {3'b0, condPass}, {3'b0, vecs[i].expPass});
        end

        // Full sweep of conditions and flag values.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'(f), 4'(c), 1'b0, 1'b0);
                checkOutput($sformatf("sweep cond=%h flags=%b", c, 4'(f)),
                            {3'b0, condPass}, {3'b0, refCond(4'(c), 4'(f))});
            end
        end

        // Sweep ran frozen, so status must not have moved.
        idle();
        checkOutput("sweep status held", statusOut, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
